div_iter_param: RTL and testbench
=================================

Name: div_iter_param

Overview:
- Parametrised iterative restoring divider, one quotient bit per clock, for the CPU execute stage (DIV/DIVU) and other multi-cycle arithmetic users.
- Next generation of the fixed 32-bit radix-2 divider; adds:
  - WIDTH parameter
  - valid/ready handshake on both input and output, with result hold under backpressure
  - flush/cancel
  - defined divide-by-zero result and flag
- Single rising-edge clock domain.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (≥ 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  abort any operation in progress; discard any held result.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept an operation.
- sign  in  1  1 = signed (two's complement), 0 = unsigned; sampled on accept.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  quotient, truncated toward zero.
- remainder  out  WIDTH  remainder; sign follows the dividend.
- div_by_zero  out  1  set with out_valid when b == 0.
- busy  out  1  state != IDLE (pipeline stall source).

Behaviour:
- Reset values (async, immediate): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - Accept occurs on an edge where in_valid & in_ready & !flush.
  - On accept, latch |a|, |b| (abs only if sign = 1), neg_q = sign & (a[W-1] ^ b[W-1]), neg_r = sign & a[W-1].
  - On accept, if b == 0: go directly to DONE. quotient = all ones, remainder = raw a, div_by_zero = 1.
  - On accept, otherwise: go to CALC with counter = 0, partial remainder = 0, shift register = |a|.
- CALC:
  - Each edge performs one restoring step:
    - trial = {rem, msb of shift} - |b|, computed WIDTH+1 bits wide.
    - If trial is non-negative, rem = trial and shifted-in q bit = 1.
    - Else rem keeps the shifted value and q bit = 0.
    - counter increments.
  - On the edge where counter == WIDTH-1:
    - Apply sign correction (negate q if neg_q, r if neg_r).
    - Register quotient/remainder, clear div_by_zero, go to DONE.
  - in_ready = 0 throughout.
- DONE:
  - out_valid = 1; quotient, remainder and div_by_zero are held stable.
  - On an edge with out_ready = 1, go to IDLE.
  - in_ready stays 0 in DONE: no accept on the same edge as result handoff.
- Latency:
  - Normal operation: out_valid is first high in the cycle starting WIDTH edges after the accept edge.
  - Divide-by-zero: out_valid is high 1 edge after accept.
  - Throughput: one operation per WIDTH+2 cycles with out_ready tied high.
- Signed overflow: MIN / -1 gives quotient = MIN (wraps), remainder = 0, no flag.
- Unsigned mode: a and b MSB carry no sign meaning; no negation is applied.
- Flush:
  - In any state, flush on an edge forces IDLE and out_valid = 0.
  - Output data registers retain their last values (don't-care).
  - Flush has priority over accept and over out_ready.
- in_valid while busy is ignored; the source must hold in_valid until in_ready.
- Operands a, b and sign are not required stable after the accept edge.
- Reset mid-operation aborts immediately; the first accept after deassertion behaves normally.

Decomposition:
- Package div_pkg:
  - state enum (IDLE/CALC/DONE).
  - Function for two's-complement abs/negate parametrised by width.
  - Localparam for the div-by-zero quotient pattern (all ones).
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, shift msb, divisor.
  - Outputs: next rem, q bit.
  - Parametrised by WIDTH; it leaves room for a later unrolled radix-4 variant instantiating two.

Test Plan (WIDTH=32 unless noted):
- Signed: a = 0xFFFFFFF9 (-7), b = 2 → out_valid exactly 32 cycles after accept; quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF, div_by_zero = 0.
- Unsigned: a = 0xFFFFFFFF, b = 0x10 → quotient = 0x0FFFFFFF, remainder = 0xF. The same operands signed give quotient = 0, remainder = 0xFFFFFFFF.
- Divide by zero: a = 5, b = 0, sign = 1 → out_valid 1 cycle after accept; quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0. Also signed 0x80000000 / 1 → quotient = 0x80000000, remainder = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → outputs stable, in_ready = 0, busy = 1. out_ready = 1 → IDLE next cycle, and a back-to-back op (100 / 7) gives quotient 14, remainder 2.
- Flush/reset: flush on the 10th CALC cycle → out_valid never rises, in_ready = 1 next cycle, new op correct. Repeat with rst pulse mid-CALC → all outputs return to reset values immediately. Rerun random regression at WIDTH = 8 and 64 against a reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider family.
// Pure declarations: no latency, no flow control.
// Negation runs at MAXW bits; callers truncate, since two's-complement low bits do not depend on width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAXW = 128;

    // Quotient reported for a zero divisor, truncated to the instance width
    localparam logic [MAXW-1:0] DIV0_Q = '1;

    function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] v, input logic en);
        return en ? (~v + MAXW'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
// Combinational, zero latency; no flow control.
// The caller guarantees i_rem < i_div, so the WIDTH+1 bit trial has bit WIDTH set exactly when it is negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_trial;

    always_comb begin
        w_trial = {i_rem, i_msb} - {1'b0, i_div};
        o_qbit  = ~w_trial[WIDTH];
        // On restore the shifted value already fits WIDTH bits, because it is below the divisor
        o_rem   = o_qbit ? w_trial[WIDTH-1:0] : {i_rem[WIDTH-2:0], i_msb};
    end

endmodule

// File: rtl/div_iter_param.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Latency: WIDTH edges from accept to out_valid, or 0 extra edges for a zero divisor.
// Backpressure: the result is held in DONE until out_ready; in_ready is low whenever busy.
module div_iter_param
    import div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem, r_shift, r_div;
    logic [WIDTH-1:0] r_quot, r_remo;
    logic             r_neg_q, r_neg_r, r_dbz;

    logic             w_accept, w_last, w_b_zero, w_qbit;
    logic [WIDTH-1:0] w_rem_nxt, w_q_fin, w_abs_a, w_abs_b;

    assign w_b_zero = (b == '0);
    assign w_last   = (r_state == CALC) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_abs_a  = WIDTH'(cond_neg(MAXW'(a), sign & a[WIDTH-1]));
    assign w_abs_b  = WIDTH'(cond_neg(MAXW'(b), sign & b[WIDTH-1]));
    assign w_q_fin  = {r_shift[WIDTH-2:0], w_qbit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_shift[WIDTH-1]),
        .i_div  (r_div),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_accept = in_valid & ~flush;
                if (w_accept) w_state_nxt = w_b_zero ? DONE : CALC;
            end
            CALC: if (w_last) w_state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Flush wins over accept and over result handoff
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_shift <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_shift <= w_abs_a;
            r_div   <= w_abs_b;
            r_neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= sign & a[WIDTH-1];
            if (w_b_zero) begin
                r_quot <= WIDTH'(DIV0_Q);
                r_remo <= a;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == CALC && !flush) begin
            r_rem   <= w_rem_nxt;
            r_shift <= w_q_fin;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_quot <= WIDTH'(cond_neg(MAXW'(w_q_fin), r_neg_q));
                r_remo <= WIDTH'(cond_neg(MAXW'(w_rem_nxt), r_neg_r));
                r_dbz  <= 1'b0;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench: directed cases on a 32-bit divider, random regression on 8/32/64-bit instances.
// All instances share controls; the narrow/wide ones take low slices of the operand buses.
module tb_div_iter_param;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, sign;
    logic [63:0] a_w, b_w;

    logic        ir8, ov8, z8, bs8;
    logic [7:0]  q8, r8;
    logic        ir32, ov32, z32, bs32;
    logic [31:0] q32, r32;
    logic        ir64, ov64, z64, bs64;
    logic [63:0] q64, r64;

    exp_t sb8[$], sb32[$], sb64[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_iter_param #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .sign(sign), .a(a_w[31:0]), .b(b_w[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .quotient(q32), .remainder(r32), .div_by_zero(z32), .busy(bs32));

    div_iter_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
        .sign(sign), .a(a_w[7:0]), .b(b_w[7:0]), .out_valid(ov8), .out_ready(out_ready),
        .quotient(q8), .remainder(r8), .div_by_zero(z8), .busy(bs8));

    div_iter_param #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .sign(sign), .a(a_w), .b(b_w), .out_valid(ov64), .out_ready(out_ready),
        .quotient(q64), .remainder(r64), .div_by_zero(z64), .busy(bs64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: magnitudes divided with the native operators, then sign-fixed and masked to w bits
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [63:0] m, ua, ub, uq, ur;
        logic        an, bn;
        exp_t        e;
        m  = (64'd1 << w) - 64'd1;
        an = s & a[w-1];
        bn = s & b[w-1];
        ua = (an ? -a : a) & m;
        ub = (bn ? -b : b) & m;
        if (ub == 64'd0) begin
            e.q = m;
            e.r = a & m;
            e.z = 1'b1;
        end else begin
            uq  = ua / ub;
            ur  = ua % ub;
            e.q = ((an ^ bn) ? -uq : uq) & m;
            e.r = (an ? -ur : ur) & m;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic op32(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int elat, input int hold);
        exp_t e;
        int   lat;
        a_w      = {32'h0, ia};
        b_w      = {32'h0, ib};
        sign     = is;
        in_valid = 1'b1;
        sb32.push_back('{q: 64'(eq), r: 64'(er), z: ez});
        chk("in_ready_at_accept", 64'(ir32), 64'd1);
        tick;
        in_valid = 1'b0;
        a_w      = {$urandom, $urandom};
        b_w      = {$urandom, $urandom};
        sign     = ~is;
        lat = 0;
        while (!ov32 && lat < 200) begin
            tick;
            lat++;
        end
        chk("latency", 64'(lat), 64'(elat));
        e = sb32.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("hold_quotient", 64'(q32), e.q);
            chk("hold_remainder", 64'(r32), e.r);
            chk("hold_in_ready", 64'(ir32), 64'd0);
            chk("hold_busy", 64'(bs32), 64'd1);
            tick;
        end
        chk("quotient", 64'(q32), e.q);
        chk("remainder", 64'(r32), e.r);
        chk("div_by_zero", 64'(z32), 64'(e.z));
        chk("out_valid", 64'(ov32), 64'd1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("out_valid_after_handoff", 64'(ov32), 64'd0);
        chk("in_ready_after_handoff", 64'(ir32), 64'd1);
    endtask

    initial begin
        logic        seen;
        logic [63:0] ra, rb;
        logic        rs;
        int          cyc;
        exp_t        e;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sign = 1'b0;
        a_w = '0; b_w = '0;
        #3;
        chk("rst_in_ready", 64'(ir32), 64'd1);
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_busy", 64'(bs32), 64'd0);
        chk("rst_quotient", 64'(q32), 64'd0);
        chk("rst_remainder", 64'(r32), 64'd0);
        chk("rst_div_by_zero", 64'(z32), 64'd0);
        #4 rst = 1'b0;
        tick;

        op32(32'hFFFF_FFF9, 32'd2,  1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 0);
        op32(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF,         1'b0, 32, 0);
        op32(32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0,         32'hFFFF_FFFF, 1'b0, 32, 0);
        op32(32'd5,         32'd0,  1'b1, 32'hFFFF_FFFF, 32'd5,         1'b1, 0,  0);
        op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0,  1'b0, 32, 0);
        op32(32'h8000_0000, 32'd1,  1'b1, 32'h8000_0000, 32'h0,         1'b0, 32, 0);

        op32(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 32, 10);
        op32(32'd100,  32'd7, 1'b0, 32'd14,  32'd2, 1'b0, 32, 0);

        a_w = 64'd1000; b_w = 64'd3; sign = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_in_ready", 64'(ir32), 64'd1);
        chk("flush_out_valid", 64'(ov32), 64'd0);
        chk("flush_busy", 64'(bs32), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick;
            seen = seen | ov32;
        end
        chk("flush_no_out_valid", 64'(seen), 64'd0);
        op32(32'd12347, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_F65B, 32'd2, 1'b0, 32, 0);

        a_w = 64'd1000; b_w = 64'd3; sign = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(ir32), 64'd1);
        chk("mid_rst_out_valid", 64'(ov32), 64'd0);
        chk("mid_rst_busy", 64'(bs32), 64'd0);
        chk("mid_rst_quotient", 64'(q32), 64'd0);
        chk("mid_rst_remainder", 64'(r32), 64'd0);
        chk("mid_rst_div_by_zero", 64'(z32), 64'd0);
        rst = 1'b0;
        tick;
        op32(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32, 0);

        // Random regression across all three widths; flush first so every instance starts idle
        flush = 1'b1;
        tick;
        flush = 1'b0;
        repeat (150) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = 64'd0;
                1: rb = rb >> $urandom_range(1, 62);
                2: rb = '1;
                3: begin ra = 64'h8000_0000_8000_0080; rb = '1; end
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            sb8.push_back(model(8, ra, rb, rs));
            sb32.push_back(model(32, ra, rb, rs));
            sb64.push_back(model(64, ra, rb, rs));
            a_w = ra; b_w = rb; sign = rs; in_valid = 1'b1;
            chk("rnd_in_ready", 64'({ir8, ir32, ir64}), 64'b111);
            tick;
            in_valid = 1'b0;
            a_w = {$urandom, $urandom};
            b_w = {$urandom, $urandom};
            sign = ~rs;
            cyc = 0;
            while (!(ov8 && ov32 && ov64) && cyc < 200) begin
                tick;
                cyc++;
            end
            chk("rnd_done_in_time", 64'(cyc < 200), 64'd1);
            repeat ($urandom_range(0, 2)) tick;
            e = sb8.pop_front();
            chk("rnd8_quotient", 64'(q8), e.q);
            chk("rnd8_remainder", 64'(r8), e.r);
            chk("rnd8_div_by_zero", 64'(z8), 64'(e.z));
            e = sb32.pop_front();
            chk("rnd32_quotient", 64'(q32), e.q);
            chk("rnd32_remainder", 64'(r32), e.r);
            chk("rnd32_div_by_zero", 64'(z32), 64'(e.z));
            e = sb64.pop_front();
            chk("rnd64_quotient", q64, e.q);
            chk("rnd64_remainder", r64, e.r);
            chk("rnd64_div_by_zero", 64'(z64), 64'(e.z));
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
